// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state type and line levels for the UART transmitter
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter emitting a tick on the last cycle of each period
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, start/data(LSB first)/even parity/stop frame out on tx
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [2:0] DATA_LAST = 3'(DATA_W - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || DATA_W < 5 || DATA_W > 8) begin : g_bad_params
        $error("uart_tx: illegal parameter combination");
    end

    uart_tx_state_e    state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [2:0]        idx, idx_n;
    logic              par, par_n, tx_n, tick;

    assign tx_ready = state == IDLE;
    assign tx_busy  = state != IDLE;

    // held clear while idle so the first bit period starts right after the handshake
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tx_ready),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        par_n   = par;
        case (state)
            IDLE: if (tx_valid) begin
                state_n = START;
                shreg_n = tx_data;
                par_n   = ^tx_data;
                idx_n   = '0;
            end
            START:  state_n = tick ? DATA : START;
            DATA: if (tick) begin
                shreg_n = shreg >> 1;
                idx_n   = idx == DATA_LAST ? '0 : idx + 3'd1;
                state_n = idx != DATA_LAST ? DATA : PARITY_EN != 0 ? PARITY : STOP;
            end
            PARITY: state_n = tick ? STOP : PARITY;
            STOP: if (tick) begin
                idx_n   = idx == STOP_LAST ? '0 : idx + 3'd1;
                state_n = idx == STOP_LAST ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
        // tx is registered from the next state so the line changes with the state
        tx_n = state_n == START  ? UART_START_LVL :
               state_n == DATA   ? shreg_n[0] :
               state_n == PARITY ? par_n : UART_IDLE_LVL;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            idx     <= '0;
            par     <= 1'b0;
            tx      <= UART_IDLE_LVL;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            idx     <= idx_n;
            par     <= par_n;
            tx      <= tx_n;
            tx_done <= state == STOP && tick && idx == STOP_LAST;
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + random frames on 8N1, 8E1 and 8N2 instances against a bit-list frame model
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d [3];
    logic [2:0] v = '0;
    logic [2:0] tx, rdy, busy, done;
    int         total = 0, passed = 0;
    time        t_start, t_prev;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(250_000)) u0 (
        .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(v[0]),
        .tx_ready(rdy[0]), .tx(tx[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(250_000), .PARITY_EN(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(d[1]), .tx_valid(v[1]),
        .tx_ready(rdy[1]), .tx(tx[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(250_000), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .tx_data(d[2]), .tx_valid(v[2]),
        .tx_ready(rdy[2]), .tx(tx[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic reset_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_tx%0d", tag, k), tx[k], 1);
            chk($sformatf("%s_ready%0d", tag, k), rdy[k], 1);
            chk($sformatf("%s_busy%0d", tag, k), busy[k], 0);
            chk($sformatf("%s_done%0d", tag, k), done[k], 0);
        end
    endtask

    // Entered and left at a negedge; on return the bench sits in the tx_done cycle.
    task automatic run_frame(input int k, input logic [7:0] data, input bit hold, input bit poke);
        bit fr[$];
        int len;
        fr.push_back(1'b0);
        for (int i = 0; i < 8; i++) fr.push_back(data[i]);
        if (k == 1) fr.push_back(^data);
        repeat (k == 2 ? 2 : 1) fr.push_back(1'b1);
        len = fr.size() * 4;
        d[k] = data;
        v[k] = 1'b1;
        chk($sformatf("hs_ready%0d", k), rdy[k], 1);
        @(negedge clk);
        t_start = $time;
        if (!hold) v[k] = 1'b0;
        for (int c = 1; c <= len; c++) begin
            chk($sformatf("tx%0d_%02h_c%0d", k, data, c), tx[k], fr[(c - 1) / 4]);
            chk($sformatf("busy%0d_c%0d", k, c), busy[k], 1);
            chk($sformatf("ready%0d_c%0d", k, c), rdy[k], 0);
            chk($sformatf("done%0d_c%0d", k, c), done[k], 0);
            if (poke && c == 10) begin
                d[k] = 8'h3C;
                v[k] = 1'b1;
            end
            if (poke && c == 12) v[k] = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("done%0d_end", k), done[k], 1);
        chk($sformatf("ready%0d_end", k), rdy[k], 1);
        chk($sformatf("busy%0d_end", k), busy[k], 0);
        chk($sformatf("tx%0d_end", k), tx[k], 1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) d[k] = '0;
        repeat (2) @(negedge clk);
        reset_state("por");
        rst = 1'b0;
        @(negedge clk);
        chk("done_after_frame_gone", done[0], 0);

        run_frame(0, 8'hA5, 0, 0);
        @(negedge clk);
        chk("done_one_cycle", done[0], 0);
        run_frame(1, 8'h07, 0, 0);
        @(negedge clk);
        run_frame(1, 8'h03, 0, 0);
        @(negedge clk);

        run_frame(0, 8'h00, 1, 0);
        t_prev = t_start;
        run_frame(0, 8'hFF, 0, 0);
        chk("b2b_start_gap", 32'((t_start - t_prev) / 10), 41);
        @(negedge clk);

        run_frame(0, 8'hC3, 0, 1);
        @(negedge clk);

        d[2] = 8'hA5;
        v[2] = 1'b1;
        @(negedge clk);
        v[2] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_busy", busy[2], 1);
        rst = 1'b1;
        #1;
        reset_state("async");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c % 25 == 0) chk($sformatf("idle_tx_c%0d", c), tx[2], 1);
            if (c % 25 == 0) chk($sformatf("idle_tx0_c%0d", c), tx[0], 1);
        end
        run_frame(2, 8'h55, 0, 0);
        @(negedge clk);

        for (int n = 0; n < 8; n++) begin
            run_frame(int'($urandom_range(0, 2)), 8'($urandom), 0, 0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
